// File: rtl/mem_cache_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Package  : cache_defs
// Purpose  : Geometry, FSM encoding and address field slices for mem_cache_ctrl.
// Revision : 1.0 - initial release
// ============================================================================

// Address field slices; expand against the ADDR_W/INDEX_W visible at the use site.
`define CD_TAG(a)   a[ADDR_W-1:INDEX_W+3]
`define CD_INDEX(a) a[INDEX_W+2:3]
`define CD_WSEL(a)  a[2]

package cache_defs;
  localparam int ADDR_W  = 18;
  localparam int INDEX_W = 6;
  localparam int TAG_W   = ADDR_W - INDEX_W - 3;
  localparam int LINE_W  = 64;
  localparam int WORD_W  = 32;
  localparam int NSETS   = 1 << INDEX_W;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_MISS = 2'd1,
    WR_THRU = 2'd2
  } state_t;

  function automatic logic [WORD_W-1:0] sel_word(input logic [LINE_W-1:0] line,
                                                 input logic              hi);
    return hi ? line[LINE_W-1:WORD_W] : line[WORD_W-1:0];
  endfunction
endpackage

`default_nettype wire

// File: rtl/mem_cache_ctrl_way.sv
`default_nettype none
// ============================================================================
// Module   : cache_way
// Purpose  : One way of the cache: valid/tag/line arrays, combinational lookup,
//            synchronous line fill, word write and valid clear on reset.
// Revision : 1.0 - initial release
// ============================================================================
module cache_way
  import cache_defs::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [INDEX_W-1:0] index_i,
  input  logic [TAG_W-1:0]   tag_i,
  input  logic               word_sel_i,
  output logic               valid_o,
  output logic               hit_o,
  output logic [WORD_W-1:0]  rd_word_o,
  input  logic               fill_en_i,
  input  logic [LINE_W-1:0]  fill_line_i,
  input  logic               wr_en_i,
  input  logic [WORD_W-1:0]  wr_data_i
);

  logic [NSETS-1:0]  valid_q;
  logic [TAG_W-1:0]  tag_q  [NSETS];
  logic [LINE_W-1:0] data_q [NSETS];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (fill_en_i) begin
      valid_q[index_i] <= 1'b1;
    end
  end

  // Tag/data need no reset: an entry is only ever observed through its valid bit.
  always_ff @(posedge clk) begin
    if (fill_en_i) begin
      tag_q[index_i]  <= tag_i;
      data_q[index_i] <= fill_line_i;
    end else if (wr_en_i) begin
      if (word_sel_i) begin
        data_q[index_i][LINE_W-1:WORD_W] <= wr_data_i;
      end else begin
        data_q[index_i][WORD_W-1:0] <= wr_data_i;
      end
    end
  end

  assign valid_o   = valid_q[index_i];
  assign hit_o     = valid_o && (tag_q[index_i] == tag_i);
  assign rd_word_o = sel_word(data_q[index_i], word_sel_i);

endmodule

`default_nettype wire

// File: rtl/mem_cache_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_cache_ctrl
// Purpose  : 2-way set-associative write-through, no-write-allocate cache
//            between the MEM stage and the SRAM controller. Optional hit/miss
//            counters when CACHE_STATS_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module mem_cache_ctrl
  import cache_defs::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WORD_W-1:0] data_in,
  input  logic              MEM_R_en,
  input  logic              MEM_W_en,
  output logic [WORD_W-1:0] data_out,
  output logic              cache_freeze,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [WORD_W-1:0] sram_wdata,
  output logic              sram_R_en,
  output logic              sram_W_en,
  input  logic [LINE_W-1:0] sram_rdata,
  input  logic              sram_freeze
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt
`endif
);

  logic [TAG_W-1:0]   tag_w;
  logic [INDEX_W-1:0] index_w;
  logic               wsel_w;
  logic [1:0]         valid_w;
  logic [1:0]         hit_w;
  logic [1:0]         fill_w;
  logic [1:0]         wr_w;
  logic [WORD_W-1:0]  rd_word_w [2];
  logic               hit_any_w;
  logic               victim_w;
  logic               rd_hit_done_w;
  logic               rd_miss_done_w;
  logic               wr_done_w;
  logic               unused_addr_bits_w;
  state_t             state_q;
  state_t             state_d;
  logic [NSETS-1:0]   lru_q;

  assign tag_w              = `CD_TAG(addr);
  assign index_w            = `CD_INDEX(addr);
  assign wsel_w             = `CD_WSEL(addr);
  assign unused_addr_bits_w = ^addr[1:0];

  assign sram_addr  = addr;
  assign sram_wdata = data_in;

  for (genvar i = 0; i < 2; i++) begin : g_way
    assign fill_w[i] = rd_miss_done_w && !rst && (victim_w == 1'(i));
    assign wr_w[i]   = wr_done_w && !rst && hit_w[i];

    cache_way u_way (
      .clk         (clk),
      .rst         (rst),
      .index_i     (index_w),
      .tag_i       (tag_w),
      .word_sel_i  (wsel_w),
      .valid_o     (valid_w[i]),
      .hit_o       (hit_w[i]),
      .rd_word_o   (rd_word_w[i]),
      .fill_en_i   (fill_w[i]),
      .fill_line_i (sram_rdata),
      .wr_en_i     (wr_w[i]),
      .wr_data_i   (data_in)
    );
  end

  assign hit_any_w      = |hit_w;
  assign rd_miss_done_w = (state_q == RD_MISS) && !sram_freeze;
  assign wr_done_w      = (state_q == WR_THRU) && !sram_freeze;
  assign rd_hit_done_w  = (state_q == IDLE) && MEM_R_en && !MEM_W_en && hit_any_w;

  // An invalid way always wins over the LRU pointer, way0 first.
  always_comb begin
    if (!valid_w[0]) begin
      victim_w = 1'b0;
    end else if (!valid_w[1]) begin
      victim_w = 1'b1;
    end else begin
      victim_w = lru_q[index_w];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    sram_R_en = 1'b0;
    sram_W_en = 1'b0;
    case (state_q)
      IDLE: begin
        if (MEM_W_en) begin
          state_d = WR_THRU;
        end else if (MEM_R_en && !hit_any_w) begin
          state_d = RD_MISS;
        end
      end
      RD_MISS: begin
        sram_R_en = 1'b1;
        if (!sram_freeze) state_d = IDLE;
      end
      WR_THRU: begin
        sram_W_en = 1'b1;
        if (!sram_freeze) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign cache_freeze = (MEM_R_en && !hit_any_w && !rd_miss_done_w) ||
                        (MEM_W_en && !wr_done_w);

  always_comb begin
    data_out = '0;
    if (rd_miss_done_w) begin
      data_out = sel_word(sram_rdata, wsel_w);
    end else if (MEM_R_en && hit_any_w) begin
      data_out = hit_w[1] ? rd_word_w[1] : rd_word_w[0];
    end
  end

  // LRU bit names the next victim: always the way not just touched.
  always_ff @(posedge clk) begin
    if (rst) begin
      lru_q <= '0;
    end else if (rd_miss_done_w) begin
      lru_q[index_w] <= ~victim_w;
    end else if (rd_hit_done_w || (wr_done_w && hit_any_w)) begin
      lru_q[index_w] <= hit_w[0];
    end
  end

`ifdef CACHE_STATS_EN
  logic [31:0] hit_cnt_q;
  logic [31:0] miss_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (rd_hit_done_w)  hit_cnt_q  <= hit_cnt_q + 32'd1;
      if (rd_miss_done_w) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif

endmodule

`default_nettype wire
